// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl: Avalon-MM slave that runs one AES core job per GO command.
// It drives the core's start level, waits for a synchronised done level,
// counts cycles, enforces an optional timeout, and raises a level interrupt.
module aes_job_ctrl #(
  parameter int               CNT_W           = 16,
  parameter logic [CNT_W-1:0] TIMEOUT_DEFAULT = CNT_W'(2000)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        aes_start,
  input  logic        aes_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] timeout_val_q;
  logic             aes_start_q;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             irq_en_q;
  logic             irq_q;
  logic             sync1_q;
  logic             done_s_q;
  logic [31:0]      rdata_q, rdata_d;

  logic wr_en, wr_ctrl, wr_status, wr_timeout;
  logic go, to_hit, set_done, set_to, job_start, busy;

  // Upper write-data bits have no destination; fold them into a sink.
  logic wdata_unused;
  assign wdata_unused = ^writedata[31:CNT_W];

  // Counter increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign wr_en      = chipselect & ~write_n;
  assign wr_ctrl    = wr_en && (address == 2'd0);
  assign wr_status  = wr_en && (address == 2'd1);
  assign wr_timeout = wr_en && (address == 2'd2);
  assign go         = wr_ctrl & writedata[0];
  assign busy       = (state_q != S_IDLE);
  assign job_start  = (state_q == S_IDLE) && go;
  assign to_hit     = (timeout_val_q != '0) && (cnt_q == timeout_val_q - CNT_W'(1));
  assign set_done   = (state_q == S_RUN) && done_s_q;
  assign set_to     = (state_q == S_RUN) && !done_s_q && to_hit;

  // Two-flop synchroniser for the core's asynchronous done level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      done_s_q <= 1'b0;
    end else begin
      sync1_q  <= aes_done;
      done_s_q <= sync1_q;
    end
  end

  // Job sequencer: start level, cycle counter and latched job length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      aes_start_q <= 1'b0;
      cnt_q       <= '0;
      cycles_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q     <= S_RUN;
            aes_start_q <= 1'b1;
            cnt_q       <= '0;
          end
        end
        S_RUN: begin
          cnt_q <= sat_inc(cnt_q);
          if (done_s_q || to_hit) begin
            state_q     <= S_DRAIN;
            aes_start_q <= 1'b0;
            cycles_q    <= cnt_q;
          end
        end
        S_DRAIN: begin
          // Wait for the core to drop done so the next job sees a clean edge.
          if (!done_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          aes_start_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status next-state: GO and W1C clear, hardware set wins a collision.
  always_comb begin
    done_d    = done_q;
    timeout_d = timeout_q;
    if (job_start) begin
      done_d    = 1'b0;
      timeout_d = 1'b0;
    end
    if (wr_status && writedata[1]) done_d    = 1'b0;
    if (wr_status && writedata[2]) timeout_d = 1'b0;
    if (set_done) done_d    = 1'b1;
    if (set_to)   timeout_d = 1'b1;
  end

  // Sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Software-writable configuration: interrupt enable and timeout limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_q      <= 1'b0;
      timeout_val_q <= TIMEOUT_DEFAULT;
    end else begin
      if (wr_ctrl)    irq_en_q      <= writedata[1];
      if (wr_timeout) timeout_val_q <= writedata[CNT_W-1:0];
    end
  end

  // Registered level interrupt from the sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_en_q & (done_q | timeout_q);
  end

  // Read mux, registered every cycle with no read strobe.
  always_comb begin
    rdata_d = 32'd0;
    case (address)
      2'd0: rdata_d = {30'd0, irq_en_q, 1'b0};
      2'd1: rdata_d = {29'd0, timeout_q, done_q, busy};
      2'd2: rdata_d = {{(32-CNT_W){1'b0}}, timeout_val_q};
      2'd3: rdata_d = {{(32-CNT_W){1'b0}}, cycles_q};
      default: rdata_d = 32'd0;
    endcase
  end

  // Read data register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= 32'd0;
    else          rdata_q <= rdata_d;
  end

  assign readdata  = rdata_q;
  assign irq       = irq_q;
  assign aes_start = aes_start_q;

endmodule
